// File: rtl/memory_param.sv
// Parametrised single-port synchronous RAM used as a chip-selected slave on
// the shared tristate data bus. It has a one-cycle registered read with a valid
// flag, and a sequential clear engine that zeroes every word after reset or on
// request. Accesses that arrive while the clear engine is running are rejected
// with a one-cycle pulse.
module memory_param #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] I,
    input  logic [ADDR_W-1:0] address,
    input  logic              chipselect,
    input  logic              read,
    input  logic              write,
    input  logic              clear,
    output logic [DATA_W-1:0] O,
    output logic              valid,
    output logic              busy,
    output logic              rejected
);

    localparam int DEPTH = 2 ** ADDR_W;

    typedef enum logic {
        CLEAR = 1'b0,
        IDLE  = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   clr_ptr_q, clr_ptr_d;
    logic [DATA_W-1:0]   rd_q, rd_d;
    logic                valid_q, valid_d;
    logic                rejected_q, rejected_d;
    logic [DATA_W-1:0]   mem_q [DEPTH];

    // Shared write port: the clear engine and bus writes never overlap.
    logic                we;
    logic [ADDR_W-1:0]   waddr;
    logic [DATA_W-1:0]   wdata;
    logic                rd_en;

    // Next-state, write-port steering and read acceptance.
    always_comb begin
        state_d    = state_q;
        clr_ptr_d  = clr_ptr_q;
        we         = 1'b0;
        waddr      = address;
        wdata      = I;
        rd_en      = 1'b0;
        valid_d    = 1'b0;
        rejected_d = 1'b0;
        unique case (state_q)
            CLEAR: begin
                // One word per edge; the terminal count is the all-ones pointer.
                we         = 1'b1;
                waddr      = clr_ptr_q;
                wdata      = '0;
                clr_ptr_d  = clr_ptr_q + ADDR_W'(1);
                rejected_d = chipselect && (read || write);
                if (&clr_ptr_q) begin
                    state_d = IDLE;
                end
            end
            IDLE: begin
                if (clear) begin
                    // A clear request swallows any access made in the same cycle.
                    state_d   = CLEAR;
                    clr_ptr_d = '0;
                end else begin
                    we      = chipselect && write;
                    rd_en   = chipselect && read;
                    valid_d = rd_en;
                end
            end
            default: state_d = CLEAR;
        endcase
        rd_d = rd_en ? mem_q[address] : rd_q;
    end

    // Control and read-register update with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= CLEAR;
            clr_ptr_q  <= '0;
            rd_q       <= '0;
            valid_q    <= 1'b0;
            rejected_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            clr_ptr_q  <= clr_ptr_d;
            rd_q       <= rd_d;
            valid_q    <= valid_d;
            rejected_q <= rejected_d;
        end
    end

    // Array write; the read above sees the old word, giving read-before-write.
    always_ff @(posedge clk) begin
        if (!reset && we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign O        = valid_q ? rd_q : {DATA_W{1'bz}};
    assign valid    = valid_q;
    assign busy     = (state_q == CLEAR);
    assign rejected = rejected_q;

endmodule
